izh_neuron_scheduler: RTL and testbench

//   Time-multiplexes one shared Izhikevich update datapath across NUM_NEURONS neurons.

---
 rtl/izh_neuron_scheduler.sv | 127 ++++++++++++
 tb/tb_izh_neuron_scheduler.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/izh_neuron_scheduler.sv
// Shares one Izhikevich update datapath across NUM_NEURONS neurons, one timestep per start pulse.
// Holds per-neuron v/u/I state and publishes the spike vector of each completed step.
module izh_neuron_scheduler #(
  parameter int          NUM_NEURONS = 8,
  parameter int          IDX_W       = $clog2(NUM_NEURONS),
  parameter logic [31:0] V_RST       = 32'hFFFF_4CCD,
  parameter logic [31:0] U_RST       = 32'hFFFF_CCCD
) (
  input  logic                   CLOCK_50,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   cfg_we,
  input  logic [IDX_W-1:0]       cfg_idx,
  input  logic [31:0]            cfg_i,
  output logic                   busy,
  output logic                   step_done,
  output logic [NUM_NEURONS-1:0] spike_vec,
  output logic [15:0]            step_count,
  output logic                   dp_req_valid,
  input  logic                   dp_req_ready,
  output logic [31:0]            dp_v,
  output logic [31:0]            dp_u,
  output logic [31:0]            dp_i,
  input  logic                   dp_rsp_valid,
  input  logic [31:0]            dp_v_new,
  input  logic [31:0]            dp_u_new,
  input  logic                   dp_spike
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRB, DONE} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [IDX_W-1:0]       idx;
  logic [NUM_NEURONS-1:0] shadow;
  logic                   last;
  logic [31:0]            v_mem [NUM_NEURONS];
  logic [31:0]            u_mem [NUM_NEURONS];
  logic [31:0]            i_mem [NUM_NEURONS];

  assign last = (idx == IDX_W'(NUM_NEURONS - 1));

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ISSUE;
      ISSUE:   if (dp_req_ready) state_next = WAIT;
      WAIT:    if (dp_rsp_valid) state_next = WRB;
      WRB:     state_next = last ? DONE : ISSUE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    dp_req_valid = (state == ISSUE);
  end

  // Operands are read live from the state arrays, so I is sampled at issue time.
  always_comb begin
    dp_v = '0;
    dp_u = '0;
    dp_i = '0;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      if (idx == IDX_W'(n)) begin
        dp_v = v_mem[n];
        dp_u = u_mem[n];
        dp_i = i_mem[n];
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      idx        <= '0;
      shadow     <= '0;
      spike_vec  <= '0;
      step_count <= '0;
      step_done  <= 1'b0;
    end else begin
      step_done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            idx    <= '0;
            shadow <= '0;
          end
        end
        WRB: begin
          shadow <= shadow | (NUM_NEURONS'(dp_spike) << idx);
          if (!last) idx <= idx + IDX_W'(1);
        end
        DONE: begin
          spike_vec  <= shadow;
          step_count <= step_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Out-of-range cfg_idx never matches any neuron, so such writes are dropped.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        v_mem[n] <= V_RST;
        u_mem[n] <= U_RST;
        i_mem[n] <= '0;
      end
    end else begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        if (state == WRB && idx == IDX_W'(n)) begin
          v_mem[n] <= dp_v_new;
          u_mem[n] <= dp_u_new;
        end
        if (cfg_we && cfg_idx == IDX_W'(n)) i_mem[n] <= cfg_i;
      end
    end
  end

endmodule

// File: tb/tb_izh_neuron_scheduler.sv
// Directed bench for izh_neuron_scheduler with an echo datapath (v+1, u+2, 1-cycle response).
// IDX_W is widened to 4 so that an out-of-range cfg_idx of 8 can be driven.
module tb_izh_neuron_scheduler;

  localparam int          N     = 8;
  localparam int          IW    = 4;
  localparam logic [31:0] V_RST = 32'hFFFF_4CCD;
  localparam logic [31:0] U_RST = 32'hFFFF_CCCD;

  logic          CLOCK_50 = 1'b0;
  logic          reset_n  = 1'b0;
  logic          start    = 1'b0;
  logic          cfg_we   = 1'b0;
  logic [IW-1:0] cfg_idx  = '0;
  logic [31:0]   cfg_i    = '0;
  logic          busy;
  logic          step_done;
  logic [N-1:0]  spike_vec;
  logic [15:0]   step_count;
  logic          dp_req_valid;
  logic          dp_req_ready = 1'b1;
  logic [31:0]   dp_v, dp_u, dp_i;
  logic          dp_rsp_valid;
  logic [31:0]   dp_v_new, dp_u_new;
  logic          dp_spike;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int nidx;
  int gen    = 0;
  logic [N-1:0] spike_mask = '0;
  logic [31:0]  exp_i [N];
  logic [31:0]  log_v [16];
  logic [31:0]  log_u [16];
  logic [31:0]  log_i [16];

  typedef struct {
    logic [N-1:0] spikes;
    int           bp;
    int           exp_lat;
    logic [N-1:0] exp_vec;
    logic [15:0]  exp_cnt;
  } vec_t;

  vec_t tbl [4];

  izh_neuron_scheduler #(.NUM_NEURONS(N), .IDX_W(IW)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_i(cfg_i), .busy(busy), .step_done(step_done),
    .spike_vec(spike_vec), .step_count(step_count), .dp_req_valid(dp_req_valid),
    .dp_req_ready(dp_req_ready), .dp_v(dp_v), .dp_u(dp_u), .dp_i(dp_i),
    .dp_rsp_valid(dp_rsp_valid), .dp_v_new(dp_v_new), .dp_u_new(dp_u_new),
    .dp_spike(dp_spike)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Echo datapath; also logs the operands of every accepted request by issue order.
  always @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      dp_rsp_valid <= 1'b0;
      dp_v_new     <= '0;
      dp_u_new     <= '0;
      dp_spike     <= 1'b0;
      nidx         <= 0;
    end else begin
      dp_rsp_valid <= dp_req_valid && dp_req_ready;
      if (dp_req_valid && dp_req_ready) begin
        dp_v_new           <= dp_v + 32'd1;
        dp_u_new           <= dp_u + 32'd2;
        dp_spike           <= spike_mask[nidx[2:0]];
        log_v[nidx[3:0]]   <= dp_v;
        log_u[nidx[3:0]]   <= dp_u;
        log_i[nidx[3:0]]   <= dp_i;
        nidx               <= nidx + 1;
      end else if (start && !busy) begin
        nidx <= 0;
      end
    end
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input int idx, input logic [31:0] val);
    cfg_we  = 1'b1;
    cfg_idx = IW'(idx);
    cfg_i   = val;
    tick();
    cfg_we  = 1'b0;
  endtask

  task automatic start_step(output int t0);
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int t0, output int lat);
    while (!step_done && (cyc - t0) < 400) tick();
    lat = cyc - t0;
    if (!step_done) checkOutput("step_done timeout", 32'(step_done), 32'd1);
  endtask

  task automatic check_ops(input string tag, input int g);
    for (int n = 0; n < N; n++) begin
      checkOutput($sformatf("%s v[%0d]", tag, n), log_v[n], V_RST + 32'(g));
      checkOutput($sformatf("%s u[%0d]", tag, n), log_u[n], U_RST + 32'(2 * g));
      checkOutput($sformatf("%s i[%0d]", tag, n), log_i[n], exp_i[n]);
    end
  endtask

  task automatic applyStimulus(input vec_t tv, output int lat, output logic stable);
    int t0;
    logic [N-1:0] prev;
    bit bp_done;
    spike_mask = tv.spikes;
    prev       = spike_vec;
    stable     = 1'b1;
    bp_done    = 1'b0;
    start_step(t0);
    while (!step_done && (cyc - t0) < 400) begin
      if (tv.bp > 0 && !bp_done && nidx == 2 && dp_req_valid) begin
        dp_req_ready = 1'b0;
        for (int c = 0; c < tv.bp; c++) begin
          checkOutput("stall valid", 32'(dp_req_valid), 32'd1);
          checkOutput("stall dp_v", dp_v, V_RST + 32'(gen));
          checkOutput("stall dp_u", dp_u, U_RST + 32'(2 * gen));
          checkOutput("stall dp_i", dp_i, exp_i[2]);
          tick();
        end
        dp_req_ready = 1'b1;
        bp_done      = 1'b1;
      end else begin
        tick();
        if (!step_done && spike_vec !== prev) stable = 1'b0;
      end
    end
    lat = cyc - t0;
    if (!step_done) checkOutput("step_done timeout", 32'(step_done), 32'd1);
  endtask

  initial begin
    int lat, t0, extra, guard;
    logic stable;

    tbl[0] = '{spikes: 8'h00, bp: 0, exp_lat: 25, exp_vec: 8'h00, exp_cnt: 16'd1};
    tbl[1] = '{spikes: 8'h42, bp: 0, exp_lat: 25, exp_vec: 8'h42, exp_cnt: 16'd2};
    tbl[2] = '{spikes: 8'h00, bp: 5, exp_lat: 30, exp_vec: 8'h00, exp_cnt: 16'd3};
    tbl[3] = '{spikes: 8'h81, bp: 0, exp_lat: 25, exp_vec: 8'h81, exp_cnt: 16'd4};

    for (int n = 0; n < N; n++) exp_i[n] = '0;

    tick();
    tick();
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset step_done", 32'(step_done), 32'd0);
    checkOutput("reset spike_vec", 32'(spike_vec), 32'd0);
    checkOutput("reset step_count", 32'(step_count), 32'd0);
    checkOutput("reset req_valid", 32'(dp_req_valid), 32'd0);
    reset_n = 1'b1;
    tick();

    for (int n = 0; n < N; n++) begin
      exp_i[n] = {16'(n), 16'h0100};
      cfg_write(n, exp_i[n]);
    end

    for (int k = 0; k < 4; k++) begin
      applyStimulus(tbl[k], lat, stable);
      checkOutput($sformatf("vec%0d latency", k), 32'(lat), 32'(tbl[k].exp_lat));
      checkOutput($sformatf("vec%0d spike_vec", k), 32'(spike_vec), 32'(tbl[k].exp_vec));
      checkOutput($sformatf("vec%0d step_count", k), 32'(step_count), 32'(tbl[k].exp_cnt));
      checkOutput($sformatf("vec%0d busy at done", k), 32'(busy), 32'd0);
      checkOutput($sformatf("vec%0d spike_vec stable", k), 32'(stable), 32'd1);
      checkOutput($sformatf("vec%0d issue count", k), 32'(nidx), 32'd8);
      check_ops($sformatf("vec%0d", k), gen);
      gen++;
    end

    // step_count wrap
    force dut.step_count = 16'hFFFF;
    tick();
    release dut.step_count;
    tick();
    spike_mask = 8'h24;
    start_step(t0);
    wait_done(t0, lat);
    checkOutput("wrap step_count", 32'(step_count), 32'd0);
    checkOutput("wrap spike_vec", 32'(spike_vec), 32'h24);
    check_ops("wrap", gen);
    gen++;

    // config race: neuron 0 already issued, neuron 7 not yet, index 8 dropped
    spike_mask = 8'h18;
    start_step(t0);
    guard = 0;
    while (nidx < 3 && guard < 100) begin tick(); guard++; end
    checkOutput("race reached n3", 32'(nidx >= 3), 32'd1);
    cfg_write(0, 32'h0006_0000);
    cfg_write(7, 32'h0006_0000);
    cfg_write(8, 32'hDEAD_BEEF);
    wait_done(t0, lat);
    exp_i[7] = 32'h0006_0000;
    check_ops("race", gen);
    checkOutput("race step_count", 32'(step_count), 32'd1);
    checkOutput("race spike_vec", 32'(spike_vec), 32'h18);
    gen++;
    exp_i[0] = 32'h0006_0000;

    // start while busy is ignored
    spike_mask = 8'h24;
    start_step(t0);
    guard = 0;
    while (nidx < 4 && guard < 100) begin tick(); guard++; end
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(t0, lat);
    checkOutput("busy-start latency", 32'(lat), 32'd25);
    check_ops("busy-start", gen);
    gen++;
    extra = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (dp_req_valid) extra++;
    end
    checkOutput("busy-start no extra step", 32'(extra), 32'd0);
    checkOutput("busy-start step_count", 32'(step_count), 32'd2);
    checkOutput("busy-start spike_vec", 32'(spike_vec), 32'h24);

    // reset during WAIT of neuron 3
    spike_mask = 8'hFF;
    start_step(t0);
    guard = 0;
    while (!(nidx == 4 && busy && !dp_req_valid) && guard < 100) begin tick(); guard++; end
    checkOutput("mid reset reached wait3", 32'(nidx), 32'd4);
    reset_n = 1'b0;
    #2;
    checkOutput("mid reset busy", 32'(busy), 32'd0);
    checkOutput("mid reset step_count", 32'(step_count), 32'd0);
    checkOutput("mid reset spike_vec", 32'(spike_vec), 32'd0);
    checkOutput("mid reset req_valid", 32'(dp_req_valid), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    extra = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (dp_req_valid) extra++;
    end
    checkOutput("post reset idle", 32'(extra), 32'd0);
    gen = 0;
    for (int n = 0; n < N; n++) exp_i[n] = '0;
    spike_mask = 8'h42;
    start_step(t0);
    wait_done(t0, lat);
    checkOutput("post reset latency", 32'(lat), 32'd25);
    checkOutput("post reset step_count", 32'(step_count), 32'd1);
    checkOutput("post reset spike_vec", 32'(spike_vec), 32'h42);
    check_ops("post reset", gen);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
